pipe_ctrl: RTL

//  Central hazard/stall/flush sequencer for the 5-stage npc core (IF/ID/EX/MEM/WB).

---
 rtl/pipe_ctrl_if.sv | 56 +++++
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard/control bundle between the npc pipeline and its sequencer.
// master: pipeline side (drives hazards); slave: pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int CNT_W   = 32,
  parameter int RADDR_W = 5
);
  logic               ifu_busy;
  logic               exu_busy;
  logic               lsu_busy;
  logic [RADDR_W-1:0] id_rs1;
  logic [RADDR_W-1:0] id_rs2;
  logic               id_use_rs1;
  logic               id_use_rs2;
  logic [RADDR_W-1:0] ex_rd;
  logic               ex_is_load;
  logic               ex_redirect;
  logic               mem_trap;
  logic               wb_ebreak;

  logic               if_ena;
  logic               id_ena;
  logic               ex_ena;
  logic               mem_ena;
  logic               wb_ena;
  logic               id_flush;
  logic               ex_flush;
  logic               mem_flush;
  logic               wb_flush;
  logic [1:0]         pc_sel;
  logic               ifu_kill;
  logic               halted;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  modport master (
    output ifu_busy, exu_busy, lsu_busy,
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_is_load, ex_redirect,
    output mem_trap, wb_ebreak,
    input  if_ena, id_ena, ex_ena, mem_ena, wb_ena,
    input  id_flush, ex_flush, mem_flush, wb_flush,
    input  pc_sel, ifu_kill, halted,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  ifu_busy, exu_busy, lsu_busy,
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_is_load, ex_redirect,
    input  mem_trap, wb_ebreak,
    output if_ena, id_ena, ex_ena, mem_ena, wb_ena,
    output id_flush, ex_flush, mem_flush, wb_flush,
    output pc_sel, ifu_kill, halted,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard/stall/flush sequencer for the 5-stage npc core.
// Ports: clk, rst_n (async low), bus (pipe_ctrl_if.slave).
module pipe_ctrl #(
  parameter int CNT_W   = 32,
  parameter int RADDR_W = 5
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_KILL,
    S_HALT
  } state_e;

  state_e           r_state;
  state_e           w_nxt;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_flush;

  // ena = {if,id,ex,mem,wb}; flush = {id,ex,mem,wb}
  logic [4:0] w_ena;
  logic [3:0] w_flush;
  logic [1:0] w_pc_sel;
  logic       w_kill;
  logic       w_fev;
  logic       w_load_use;
  logic       w_rs1_hit;
  logic       w_rs2_hit;

  assign w_rs1_hit = bus.id_use_rs1 &&
                     (bus.id_rs1 == bus.ex_rd);
  assign w_rs2_hit = bus.id_use_rs2 &&
                     (bus.id_rs2 == bus.ex_rd);
  assign w_load_use = bus.ex_is_load &&
                      (bus.ex_rd != '0) &&
                      (w_rs1_hit || w_rs2_hit);

  always_comb begin
    w_ena    = 5'b11111;
    w_flush  = 4'b0000;
    w_pc_sel = 2'd0;
    w_kill   = 1'b0;
    w_fev    = 1'b0;
    w_nxt    = r_state;
    if (!rst_n) begin
      w_ena   = 5'b00000;
      w_flush = 4'b1111;
      w_nxt   = S_RUN;
    end else begin
      unique case (r_state)
        S_RUN: begin
          priority case (1'b1)
            bus.wb_ebreak: begin
              w_ena = 5'b00000;
              w_nxt = S_HALT;
            end
            bus.mem_trap && bus.lsu_busy: begin
              w_ena   = 5'b00011;
              w_flush = 4'b0010;
              w_nxt   = S_DRAIN;
            end
            bus.mem_trap: begin
              w_flush  = 4'b1110;
              w_pc_sel = 2'd2;
              w_fev    = 1'b1;
            end
            bus.lsu_busy: begin
              w_ena   = 5'b00001;
              w_flush = 4'b0001;
            end
            bus.exu_busy: begin
              w_ena   = 5'b00011;
              w_flush = 4'b0010;
            end
            bus.ex_redirect: begin
              w_pc_sel = 2'd1;
              w_flush  = 4'b1100;
              w_fev    = 1'b1;
              // response of the in-flight fetch is stale
              if (bus.ifu_busy) begin
                w_kill = 1'b1;
                w_nxt  = S_KILL;
              end
            end
            w_load_use: begin
              w_ena   = 5'b00111;
              w_flush = 4'b0100;
            end
            bus.ifu_busy: begin
              w_ena   = 5'b01111;
              w_flush = 4'b1000;
            end
            default: ;
          endcase
        end
        S_DRAIN: begin
          if (bus.wb_ebreak) begin
            w_ena = 5'b00000;
            w_nxt = S_HALT;
          end else if (bus.lsu_busy) begin
            w_ena   = 5'b00001;
            w_flush = 4'b0001;
          end else begin
            w_flush  = 4'b1110;
            w_pc_sel = 2'd2;
            w_fev    = 1'b1;
            w_nxt    = S_RUN;
          end
        end
        S_KILL: begin
          w_flush = 4'b1000;
          if (bus.ifu_busy) begin
            w_ena  = 5'b01111;
            w_kill = 1'b1;
          end else begin
            w_nxt = S_RUN;
          end
        end
        S_HALT: begin
          w_ena = 5'b00000;
        end
        default: begin
          w_nxt = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      r_state <= w_nxt;
      if (!w_ena[4] && r_state != S_HALT &&
          r_stall != '1)
        r_stall <= r_stall + 1'b1;
      if (w_fev && r_flush != '1)
        r_flush <= r_flush + 1'b1;
    end
  end

  assign bus.if_ena    = w_ena[4];
  assign bus.id_ena    = w_ena[3];
  assign bus.ex_ena    = w_ena[2];
  assign bus.mem_ena   = w_ena[1];
  assign bus.wb_ena    = w_ena[0];
  assign bus.id_flush  = w_flush[3];
  assign bus.ex_flush  = w_flush[2];
  assign bus.mem_flush = w_flush[1];
  assign bus.wb_flush  = w_flush[0];
  assign bus.pc_sel    = w_pc_sel;
  assign bus.ifu_kill  = w_kill;
  assign bus.halted    = (r_state == S_HALT);
  assign bus.stall_cnt = r_stall;
  assign bus.flush_cnt = r_flush;

endmodule
